// File: rtl/fatori_err_collector.sv
// fatori_err_collector
// Collects minority/majority/scrub error pulses from NSRC fault-tolerance
// wrappers. Each pulse is held as a pending bit. A round-robin arbiter moves
// pending bits one at a time into a small event FIFO, which the consumer
// drains with valid/ready. Saturating counters track every pulse per type
// and every pulse that was coalesced into an already-pending bit.
module fatori_err_collector #(
    parameter int NSRC       = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NSRC-1:0]           src_min_i,
    input  logic [NSRC-1:0]           src_maj_i,
    input  logic [NSRC-1:0]           src_scrub_i,
    input  logic                      clr_cnt_i,
    output logic                      evt_valid_o,
    input  logic                      evt_ready_i,
    output logic [$clog2(NSRC)-1:0]   evt_src_o,
    output logic [1:0]                evt_type_o,
    output logic                      evt_ovf_o,
    output logic                      pending_o,
    output logic [CNT_W-1:0]          min_cnt_o,
    output logic [CNT_W-1:0]          maj_cnt_o,
    output logic [CNT_W-1:0]          scrub_cnt_o,
    output logic [CNT_W-1:0]          drop_cnt_o
);

    localparam int SW = $clog2(NSRC);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = SW + 3;                 // {src, type, ovf}
    localparam int DW = $clog2(3 * NSRC + 1);   // popcount width
    localparam int XW = CNT_W + DW + 1;         // saturating-add headroom

    // Pending state and arbitration
    logic [NSRC-1:0] r_pend_min;
    logic [NSRC-1:0] r_pend_maj;
    logic [NSRC-1:0] r_pend_scrub;
    logic [NSRC-1:0] w_pend_min_next;
    logic [NSRC-1:0] w_pend_maj_next;
    logic [NSRC-1:0] w_pend_scrub_next;
    logic [NSRC-1:0] w_drop_min;
    logic [NSRC-1:0] w_drop_maj;
    logic [NSRC-1:0] w_drop_scrub;
    logic [NSRC-1:0] w_any;
    logic [NSRC-1:0] w_gnt_min;
    logic [NSRC-1:0] w_gnt_maj;
    logic [NSRC-1:0] w_gnt_scrub;
    logic [SW-1:0]   r_rr;
    logic            r_ovf;
    logic            w_can;
    logic            w_found;
    logic [SW-1:0]   w_gsrc;
    logic [1:0]      w_gtype;
    logic [SW:0]     w_idx;
    logic            w_any_drop;

    // Event FIFO
    logic [RW-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic [RW-1:0]   w_head;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;

    // Statistics: 0=min, 1=maj, 2=scrub, 3=drop
    logic [CNT_W-1:0]    r_cnt   [4];
    logic [3*NSRC-1:0]   w_cnt_vec [4];

    function automatic logic [DW-1:0] f_popcnt(input logic [3*NSRC-1:0] v);
        logic [DW-1:0] c;
        c = '0;
        for (int i = 0; i < 3 * NSRC; i++) begin
            c = c + DW'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] f_sat_add(input logic [CNT_W-1:0] c,
                                                   input logic [DW-1:0] n);
        logic [XW-1:0] s;
        s = XW'(c) + XW'(n);
        if (s > XW'({CNT_W{1'b1}})) begin
            return {CNT_W{1'b1}};
        end
        return s[CNT_W-1:0];
    endfunction

    // Per-source pending update: a grant clears the bit, a pulse sets it;
    // a pulse onto a still-set, ungranted bit is coalesced (dropped).
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        assign w_drop_min[gi]        = src_min_i[gi]   & r_pend_min[gi]   & ~w_gnt_min[gi];
        assign w_drop_maj[gi]        = src_maj_i[gi]   & r_pend_maj[gi]   & ~w_gnt_maj[gi];
        assign w_drop_scrub[gi]      = src_scrub_i[gi] & r_pend_scrub[gi] & ~w_gnt_scrub[gi];
        assign w_pend_min_next[gi]   = (r_pend_min[gi]   & ~w_gnt_min[gi])   | src_min_i[gi];
        assign w_pend_maj_next[gi]   = (r_pend_maj[gi]   & ~w_gnt_maj[gi])   | src_maj_i[gi];
        assign w_pend_scrub_next[gi] = (r_pend_scrub[gi] & ~w_gnt_scrub[gi]) | src_scrub_i[gi];
        assign w_any[gi]             = r_pend_min[gi] | r_pend_maj[gi] | r_pend_scrub[gi];
    end

    // No pass-through: only a non-full FIFO may accept a grant.
    assign w_can      = (r_count < (AW+1)'(FIFO_DEPTH));
    assign w_any_drop = |w_cnt_vec[3];

    // Round-robin source search starting at r_rr
    always_comb begin
        w_found = 1'b0;
        w_gsrc  = '0;
        w_idx   = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_idx = {1'b0, r_rr} + (SW+1)'(i);
            if (w_idx >= (SW+1)'(NSRC)) begin
                w_idx = w_idx - (SW+1)'(NSRC);
            end
            if (w_can && !w_found && w_any[w_idx[SW-1:0]]) begin
                w_found = 1'b1;
                w_gsrc  = w_idx[SW-1:0];
            end
        end
    end

    // Type priority within the chosen source: maj > scrub > min
    always_comb begin
        w_gtype     = 2'b00;
        w_gnt_min   = '0;
        w_gnt_maj   = '0;
        w_gnt_scrub = '0;
        if (w_found) begin
            if (r_pend_maj[w_gsrc]) begin
                w_gtype            = 2'b10;
                w_gnt_maj[w_gsrc]  = 1'b1;
            end else if (r_pend_scrub[w_gsrc]) begin
                w_gtype             = 2'b11;
                w_gnt_scrub[w_gsrc] = 1'b1;
            end else begin
                w_gtype            = 2'b01;
                w_gnt_min[w_gsrc]  = 1'b1;
            end
        end
    end

    // Pending bits, round-robin pointer and sticky overflow flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pend_min   <= '0;
            r_pend_maj   <= '0;
            r_pend_scrub <= '0;
            r_rr         <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_pend_min   <= w_pend_min_next;
            r_pend_maj   <= w_pend_maj_next;
            r_pend_scrub <= w_pend_scrub_next;
            if (w_found) begin
                r_rr  <= (w_gsrc == SW'(NSRC - 1)) ? '0 : w_gsrc + 1'b1;
                // The flag rides on this record; a drop now belongs to the next one.
                r_ovf <= w_any_drop;
            end else if (w_any_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign w_push  = w_found;
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && evt_ready_i;

    // FIFO storage; contents are only observed through the valid gate
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_gsrc, w_gtype, r_ovf};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign w_cnt_vec[0] = {{(2*NSRC){1'b0}}, src_min_i};
    assign w_cnt_vec[1] = {{(2*NSRC){1'b0}}, src_maj_i};
    assign w_cnt_vec[2] = {{(2*NSRC){1'b0}}, src_scrub_i};
    assign w_cnt_vec[3] = {w_drop_scrub, w_drop_maj, w_drop_min};

    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
        // Saturating statistic counter; clear beats a same-cycle increment
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_cnt[gi] <= '0;
            end else if (clr_cnt_i) begin
                r_cnt[gi] <= '0;
            end else begin
                r_cnt[gi] <= f_sat_add(r_cnt[gi], f_popcnt(w_cnt_vec[gi]));
            end
        end
    end

    assign w_head      = r_mem[r_rptr];
    assign evt_valid_o = w_valid;
    assign evt_src_o   = w_valid ? w_head[RW-1:3] : '0;
    assign evt_type_o  = w_valid ? w_head[2:1]    : 2'b00;
    assign evt_ovf_o   = w_valid ? w_head[0]      : 1'b0;
    assign pending_o   = |{r_pend_min, r_pend_maj, r_pend_scrub};
    assign min_cnt_o   = r_cnt[0];
    assign maj_cnt_o   = r_cnt[1];
    assign scrub_cnt_o = r_cnt[2];
    assign drop_cnt_o  = r_cnt[3];

endmodule
